// File: rtl/apb_slave_regs.sv
// APB completer with a bank of DEPTH read/write registers, fixed wait-state insertion
// and an error response for addresses outside the implemented range.
module apb_slave_regs #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] reg0_out
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e                r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [31:0]           w_addr32;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_setup;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic                  w_ready;

    assign w_addr32   = 32'(paddr);
    assign w_idx      = paddr[IDX_W-1:0];
    assign w_in_range = (w_addr32 < DEPTH);
    assign w_setup    = psel && !penable;
    assign w_ready    = (r_state == StAccess) && psel && penable && (r_cnt == 4'd0);

    // A setup phase restarts the transfer from any state, which also covers back-to-back.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wr_en      = 1'b0;
        if (w_setup) begin
            w_state_next = StAccess;
            w_cnt_next   = WAIT_INIT;
        end else if (r_state == StAccess) begin
            if (!psel) begin
                w_state_next = StIdle;
            end else if (penable) begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_state_next = StIdle;
                    w_wr_en      = pwrite && w_in_range;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= pwdata;
        end
    end

    // Read data is captured at setup so it is stable throughout the access phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prdata <= '0;
        end else if (w_setup && !pwrite) begin
            r_prdata <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    assign prdata   = r_prdata;
    assign pready   = w_ready;
    assign pslverr  = w_ready && !w_in_range;
    assign reg0_out = r_mem[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) on one shared bus,
// selected one at a time, checked against a register-array reference model.
module tb_apb_slave_regs;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    int         sel = 0;

    logic [7:0] prdata_v [3];
    logic       pready_v [3];
    logic       pslverr_v [3];
    logic [7:0] reg0_v [3];
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic [7:0] reg0_out;

    int         wait_of [3] = '{0, 2, 3};
    logic [7:0] model [3][16];
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    apb_slave_regs #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .psel(psel && sel == 0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .reg0_out(reg0_v[0])
    );
    apb_slave_regs #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .psel(psel && sel == 1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .reg0_out(reg0_v[1])
    );
    apb_slave_regs #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset_n(reset_n), .psel(psel && sel == 2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]),
        .pready(pready_v[2]), .pslverr(pslverr_v[2]), .reg0_out(reg0_v[2])
    );

    always_comb begin
        prdata   = prdata_v[sel];
        pready   = pready_v[sel];
        pslverr  = pslverr_v[sel];
        reg0_out = reg0_v[sel];
    end

    task automatic clear_model();
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 16; a++) model[s][a] = 8'h00;
    endtask

    task automatic idle(input int n);
        psel = 1'b0;
        penable = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered at 1 time unit after a rising edge; leaves the bus in the completion state.
    task automatic xfer(input int s, input bit wr, input logic [7:0] addr,
                        input logic [7:0] data);
        int         w;
        logic [7:0] exp_rd;
        w = wait_of[s];
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        n_tests++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_pready dut%0d: got %b want 0", s, pready);
        end
        @(posedge clk); #1;
        if (!wr) begin
            exp_rd = (addr < 16) ? model[s][addr[3:0]] : 8'h00;
            n_tests++;
            if (prdata !== exp_rd) begin
                n_fail++;
                $display("FAIL read_data dut%0d addr %h: got %h want %h", s, addr, prdata, exp_rd);
            end
        end
        penable = 1'b1;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            n_tests++;
            if (pready !== (k == w)) begin
                n_fail++;
                $display("FAIL access_pready dut%0d cycle %0d: got %b want %b", s, k, pready, k == w);
            end
            n_tests++;
            if (reg0_out !== model[s][0]) begin
                n_fail++;
                $display("FAIL reg0_hold dut%0d: got %h want %h", s, reg0_out, model[s][0]);
            end
            if (k == w) begin
                n_tests++;
                if (pslverr !== (addr >= 16)) begin
                    n_fail++;
                    $display("FAIL pslverr dut%0d addr %h: got %b want %b", s, addr, pslverr,
                             addr >= 16);
                end
            end
            @(posedge clk); #1;
        end
        if (wr && addr < 16) model[s][addr[3:0]] = data;
        n_tests++;
        if (reg0_out !== model[s][0]) begin
            n_fail++;
            $display("FAIL reg0_after dut%0d: got %h want %h", s, reg0_out, model[s][0]);
        end
    endtask

    task automatic test_reset();
        clear_model();
        reset_n = 1'b0;
        #23 reset_n = 1'b1;
        @(posedge clk); #1;
        repeat (10) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                n_tests++;
                if (prdata_v[s] !== 8'h00 || pready_v[s] !== 1'b0 || pslverr_v[s] !== 1'b0 ||
                    reg0_v[s] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d: got prdata=%h pready=%b pslverr=%b reg0=%h want 00/0/0/00",
                             s, prdata_v[s], pready_v[s], pslverr_v[s], reg0_v[s]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_no_wait();
        xfer(0, 1'b1, 8'h03, 8'hA5);
        idle(1);
        xfer(0, 1'b0, 8'h03, 8'h00);
        idle(1);
    endtask

    task automatic test_wait3();
        xfer(2, 1'b1, 8'h00, 8'h3C);
        idle(1);
        xfer(2, 1'b0, 8'h00, 8'h00);
        idle(1);
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 8'h10, 8'h77);
        idle(1);
        xfer(0, 1'b0, 8'h10, 8'h00);
        idle(1);
        for (int a = 0; a < 16; a++) xfer(0, 1'b0, 8'(a), 8'h00);
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 8'h05, 8'h11);
        xfer(0, 1'b0, 8'h05, 8'h00);
        xfer(1, 1'b1, 8'h06, 8'h22);
        xfer(1, 1'b0, 8'h06, 8'h00);
        idle(1);
    endtask

    task automatic test_abort();
        xfer(1, 1'b1, 8'h07, 8'h5E);
        idle(1);
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'hEE;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wait_pready: got %b want 0", pready);
        end
        @(posedge clk); #1;
        psel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (pready !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_pready cycle %0d: got %b want 0", k, pready);
            end
            // Re-raise psel with penable still high: not a setup, so it must be ignored.
            if (k == 1) begin
                @(posedge clk); #1;
                psel = 1'b1; pwdata = 8'h99;
            end
        end
        idle(1);
        xfer(1, 1'b0, 8'h07, 8'h00);
        idle(1);
    endtask

    task automatic test_reset_mid();
        xfer(2, 1'b1, 8'h01, 8'h42);
        idle(1);
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_pready: got %b want 0", pready);
        end
        @(posedge clk); #1;
        clear_model();
        reset_n = 1'b1;
        idle(1);
        xfer(2, 1'b0, 8'h01, 8'h00);
        idle(1);
        // Reset landing on a completion cycle must drop pready without waiting for a clock.
        xfer(0, 1'b1, 8'h00, 8'h6B);
        idle(1);
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h5A;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pready !== 1'b1) begin
            n_fail++;
            $display("FAIL complete_pready: got %b want 1", pready);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if (pready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pready_drop: got %b want 0", pready);
        end
        @(posedge clk); #1;
        clear_model();
        reset_n = 1'b1;
        idle(1);
        xfer(0, 1'b0, 8'h02, 8'h00);
        xfer(0, 1'b0, 8'h00, 8'h00);
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            xfer($urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)),
                 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 16; a++) xfer(s, 1'b0, 8'(a), 8'h00);
        idle(1);
    endtask

    initial begin
        test_reset();
        test_no_wait();
        test_wait3();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
